pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer, next generation of the core's PC block. Adds to the hold/increment/relative-jump/absolute-jump PC: subroutine call and return through a circular return-address stack (RAS), a pipeline stall input, a redirect indicator and sticky stack-fault flags. Sits between the control decoder (PS, BC), the register file (D) and instruction memory (instruction_address).

## Interface
Parameters:
- ADDR_W, 16, width of instruction_address and RAS entries
- D_W, 16, width of the register operand D
- OFFSET_W, 8, width of the signed branch offset
- RAS_DEPTH, 4, number of RAS entries (power of two, ≥2)
- RESET_VECTOR, 0, instruction_address value after reset

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  1 = freeze all state this cycle
- BC  in  1  branch condition: conditional jump taken when BC == (|D)
- PS  in  3  PC update style (see Operation)
- D  in  D_W  destination-register value (condition source, absolute target)
- offset  in  OFFSET_W  signed two's-complement relative offset
- instruction_address  out  ADDR_W  current PC, registered
- taken  out  1  registered; 1 for the cycle after a redirect was applied
- ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries, registered
- ras_overflow  out  1  sticky: a push discarded the oldest entry
- ras_underflow  out  1  sticky: a return was issued on an empty RAS

## Operation
- PS encoding: 0 HOLD, 1 INC, 2 REL, 3 ABS, 4 CALL_REL, 5 CALL_ABS, 6 RET, 7 reserved (behaves as INC).
- seq = PC + 1; rel = PC + 1 + sign_extend(offset); abs = D zero-extended or truncated to ADDR_W. All arithmetic modulo 2^ADDR_W (wraps silently).
- cond = (BC == (|D)).
- HOLD: PC unchanged. INC: PC ← seq.
- REL: PC ← cond ? rel : seq. ABS: PC ← cond ? abs : seq.
- CALL_REL / CALL_ABS: unconditional; push seq onto RAS, PC ← rel / abs.
- RET: if ras_count > 0, PC ← top entry, pop; else PC ← seq, ras_underflow ← 1, RAS unchanged.
- Push when ras_count == RAS_DEPTH: oldest entry overwritten (circular), ras_count stays RAS_DEPTH, ras_overflow ← 1.
- taken ← 1 when the next PC came from rel, abs or a RAS pop; 0 for HOLD, INC, reserved, untaken conditionals and RET-on-empty.
- stall = 1 overrides PS: PC, RAS, ras_count and flags hold; taken ← 0.
- Sticky flags clear only on reset.

## Timing
- Reset (asynchronous assert, any time including mid-operation): instruction_address = RESET_VECTOR, ras_count = 0, taken = 0, ras_overflow = 0, ras_underflow = 0. RAS contents need no clearing (count governs validity). Deassertion is sampled synchronously: first update on the first rising edge with reset high.
- Inputs sampled on rising edge; all outputs change only on that edge. One-cycle latency from PS/D/offset to instruction_address.
- D and offset must be stable at the edge at which PS selects them; no internal forwarding.
- A single edge applies at most one push or one pop; CALL and RET never combine.
- Back-to-back CALL/RET on consecutive cycles are supported at full rate.

## Test plan
- Reset then 3 cycles INC -> instruction_address 0,1,2,3; taken 0; ras_count 0; drive reset low mid-sequence -> address 0 immediately, without a clock edge.
- PC=0x0010, REL, offset=0xFE (−2), BC=1, D=0x0005 -> PC 0x000F, taken 1; same with D=0 -> PC 0x0011, taken 0.
- PC=0xFFFF, INC -> 0x0000; PC=0xFFFF, REL offset=0x01, cond true -> 0x0001 (wrap).
- PC=0x0020, CALL_ABS D=0x0100 -> PC 0x0100, ras_count 1; RET -> PC 0x0021, ras_count 0, taken 1; second RET -> PC 0x0022, ras_underflow 1.
- RAS_DEPTH=4: five CALL_ABS from PCs 0x10,0x20,0x30,0x40,0x50 -> ras_overflow 1, ras_count 4; four RETs return 0x51,0x41,0x31,0x21; fifth RET underflows.
- stall=1 during CALL_ABS with D=0x0200 -> PC, ras_count unchanged, taken 0; release stall -> call applied on the next edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a circular return-address stack.
//
// Updates the instruction address once per rising clock edge. Supported moves
// are hold, increment, conditional relative jump and conditional absolute
// jump. Calls push the return address (PC + 1) onto the return-address stack
// (RAS), and returns pop it. A stall input freezes all state for that cycle.
//
// Ports:
//   clk                 system clock; all state updates on the rising edge
//   reset               asynchronous, active-low reset
//   stall               1 = hold PC, RAS, count and flags; taken is cleared
//   BC                  branch condition; a conditional move is taken when BC == |D
//   PS                  update select: 0 HOLD, 1 INC, 2 REL, 3 ABS,
//                       4 CALL_REL, 5 CALL_ABS, 6 RET, 7 same as INC
//   D                   register operand; supplies the condition and the absolute target
//   offset              signed relative offset, applied to PC + 1
//   instruction_address current PC (registered)
//   taken               registered; 1 after a rel/abs/pop redirect
//   ras_count           number of valid RAS entries (registered)
//   ras_overflow        sticky; set when a push discards the oldest entry
//   ras_underflow       sticky; set when a return is issued on an empty RAS
module pc_sequencer #(
  parameter int                ADDR_W       = 16,
  parameter int                D_W          = 16,
  parameter int                OFFSET_W     = 8,
  parameter int                RAS_DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           BC,
  input  logic [2:0]                     PS,
  input  logic [D_W-1:0]                 D,
  input  logic signed [OFFSET_W-1:0]     offset,
  output logic [ADDR_W-1:0]              instruction_address,
  output logic                           taken,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

  localparam logic [2:0] PS_HOLD     = 3'd0;
  localparam logic [2:0] PS_INC      = 3'd1;
  localparam logic [2:0] PS_REL      = 3'd2;
  localparam logic [2:0] PS_ABS      = 3'd3;
  localparam logic [2:0] PS_CALL_REL = 3'd4;
  localparam logic [2:0] PS_CALL_ABS = 3'd5;
  localparam logic [2:0] PS_RET      = 3'd6;

  // Sign-extend (or truncate) the branch offset to the address width.
  function automatic logic [ADDR_W-1:0] sext_offset(input logic signed [OFFSET_W-1:0] o);
    logic signed [ADDR_W-1:0] r;
    r = ADDR_W'(o);
    return r;
  endfunction

  // Zero-extend or truncate the register operand to the address width.
  function automatic logic [ADDR_W-1:0] abs_target(input logic [D_W-1:0] d);
    return ADDR_W'(d);
  endfunction

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  // wr_ptr addresses the next free slot; the top of stack is wr_ptr - 1.
  // When the stack is full, wr_ptr lands on the oldest entry, so a push
  // overwrites it without extra bookkeeping.
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  top_ptr;

  logic [ADDR_W-1:0] seq_addr;
  logic [ADDR_W-1:0] rel_addr;
  logic [ADDR_W-1:0] abs_addr;
  logic              cond;

  logic [ADDR_W-1:0] pc_nxt;
  logic              taken_nxt;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              unf_set;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [PTR_W-1:0]  ptr_nxt;

  assign top_ptr  = wr_ptr - PTR_W'(1);
  assign seq_addr = instruction_address + ADDR_W'(1);
  assign rel_addr = seq_addr + sext_offset(offset);
  assign abs_addr = abs_target(D);
  assign cond     = (BC == (|D));

  // Next-state selection
  always_comb begin
    pc_nxt    = instruction_address;
    taken_nxt = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    unf_set   = 1'b0;
    if (!stall) begin
      case (PS)
        PS_HOLD: pc_nxt = instruction_address;
        PS_INC:  pc_nxt = seq_addr;
        PS_REL: begin
          pc_nxt    = cond ? rel_addr : seq_addr;
          taken_nxt = cond;
        end
        PS_ABS: begin
          pc_nxt    = cond ? abs_addr : seq_addr;
          taken_nxt = cond;
        end
        PS_CALL_REL: begin
          pc_nxt    = rel_addr;
          taken_nxt = 1'b1;
          push      = 1'b1;
        end
        PS_CALL_ABS: begin
          pc_nxt    = abs_addr;
          taken_nxt = 1'b1;
          push      = 1'b1;
        end
        PS_RET: begin
          if (ras_count != '0) begin
            pc_nxt    = ras_mem[top_ptr];
            taken_nxt = 1'b1;
            pop       = 1'b1;
          end else begin
            pc_nxt  = seq_addr;
            unf_set = 1'b1;
          end
        end
        default: pc_nxt = seq_addr;
      endcase
    end
  end

  always_comb begin
    cnt_nxt = ras_count;
    ptr_nxt = wr_ptr;
    ovf_set = 1'b0;
    if (push) begin
      ptr_nxt = wr_ptr + PTR_W'(1);
      if (ras_count == FULL) begin
        ovf_set = 1'b1;
      end else begin
        cnt_nxt = ras_count + CNT_W'(1);
      end
    end else if (pop) begin
      ptr_nxt = top_ptr;
      cnt_nxt = ras_count - CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instruction_address <= RESET_VECTOR;
      taken               <= 1'b0;
      ras_count           <= '0;
      wr_ptr              <= '0;
      ras_overflow        <= 1'b0;
      ras_underflow       <= 1'b0;
    end else begin
      instruction_address <= pc_nxt;
      taken               <= taken_nxt;
      ras_count           <= cnt_nxt;
      wr_ptr              <= ptr_nxt;
      ras_overflow        <= ras_overflow | ovf_set;
      ras_underflow       <= ras_underflow | unf_set;
    end
  end

  // Stack storage; validity is governed by ras_count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      ras_mem[wr_ptr] <= seq_addr;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        BC;
  logic [2:0]  PS;
  logic [15:0] D;
  logic signed [7:0] offset;
  logic [15:0] instruction_address;
  logic        taken;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;

  int vectors;
  int miscompares;

  pc_sequencer dut (
    .clk                 (clk),
    .reset               (reset),
    .stall               (stall),
    .BC                  (BC),
    .PS                  (PS),
    .D                   (D),
    .offset              (offset),
    .instruction_address (instruction_address),
    .taken               (taken),
    .ras_count           (ras_count),
    .ras_overflow        (ras_overflow),
    .ras_underflow       (ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the current inputs at the next rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] ps, input logic bc, input logic [15:0] d,
                       input logic [7:0] off);
    PS = ps; BC = bc; D = d; offset = off;
    step();
  endtask

  // Absolute jump with a true condition (target must be nonzero).
  task automatic go_to(input logic [15:0] a);
    drive(3'd3, 1'b1, a, 8'h00);
    chk("goto_pc", instruction_address, a);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("async_rst_pc", instruction_address, 16'h0000);
    chk("async_rst_cnt", ras_count, 3'd0);
    chk("async_rst_ovf", ras_overflow, 1'b0);
    chk("async_rst_unf", ras_underflow, 1'b0);
    chk("async_rst_taken", taken, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0; stall = 1'b0; BC = 1'b0; PS = 3'd1; D = '0; offset = '0;
    step();
    step();
    chk("rst_pc", instruction_address, 16'h0000);
    chk("rst_taken", taken, 1'b0);
    chk("rst_cnt", ras_count, 3'd0);
    chk("rst_ovf", ras_overflow, 1'b0);
    chk("rst_unf", ras_underflow, 1'b0);
    reset = 1'b1;

    // INC sequence
    for (int i = 1; i <= 3; i++) begin
      drive(3'd1, 1'b0, 16'h0000, 8'h00);
      chk("inc_pc", instruction_address, i);
      chk("inc_taken", taken, 1'b0);
      chk("inc_cnt", ras_count, 3'd0);
    end
    do_reset();

    // HOLD and reserved
    go_to(16'h0040);
    drive(3'd0, 1'b1, 16'h0001, 8'h05);
    chk("hold_pc", instruction_address, 16'h0040);
    chk("hold_taken", taken, 1'b0);
    drive(3'd7, 1'b1, 16'h0001, 8'h05);
    chk("rsvd_pc", instruction_address, 16'h0041);
    chk("rsvd_taken", taken, 1'b0);

    // Relative branch, taken and not taken
    go_to(16'h0010);
    drive(3'd2, 1'b1, 16'h0005, 8'hFE);
    chk("rel_t_pc", instruction_address, 16'h000F);
    chk("rel_t_taken", taken, 1'b1);
    go_to(16'h0010);
    drive(3'd2, 1'b1, 16'h0000, 8'hFE);
    chk("rel_nt_pc", instruction_address, 16'h0011);
    chk("rel_nt_taken", taken, 1'b0);
    // BC=0 with D=0 is a true condition
    drive(3'd3, 1'b0, 16'h0000, 8'h00);
    chk("abs_bc0_pc", instruction_address, 16'h0000);
    chk("abs_bc0_taken", taken, 1'b1);

    // Wrap-around
    go_to(16'hFFFF);
    drive(3'd1, 1'b0, 16'h0000, 8'h00);
    chk("wrap_inc", instruction_address, 16'h0000);
    go_to(16'hFFFF);
    drive(3'd2, 1'b1, 16'h0001, 8'h01);
    chk("wrap_rel", instruction_address, 16'h0001);

    // Call / return / underflow
    go_to(16'h0020);
    drive(3'd5, 1'b0, 16'h0100, 8'h00);
    chk("call_pc", instruction_address, 16'h0100);
    chk("call_cnt", ras_count, 3'd1);
    chk("call_taken", taken, 1'b1);
    drive(3'd6, 1'b0, 16'h0000, 8'h00);
    chk("ret_pc", instruction_address, 16'h0021);
    chk("ret_cnt", ras_count, 3'd0);
    chk("ret_taken", taken, 1'b1);
    chk("ret_unf0", ras_underflow, 1'b0);
    drive(3'd6, 1'b0, 16'h0000, 8'h00);
    chk("ret2_pc", instruction_address, 16'h0022);
    chk("ret2_unf", ras_underflow, 1'b1);
    chk("ret2_taken", taken, 1'b0);
    chk("ret2_cnt", ras_count, 3'd0);
    drive(3'd1, 1'b0, 16'h0000, 8'h00);
    chk("unf_sticky", ras_underflow, 1'b1);
    do_reset();

    // Overflow: five calls into a four-entry stack
    for (int i = 1; i <= 5; i++) begin
      go_to(16'(i * 16));
      drive(3'd5, 1'b0, 16'h0100, 8'h00);
      chk("ovf_call_cnt", ras_count, (i > 4) ? 4 : i);
      chk("ovf_flag", ras_overflow, (i > 4) ? 1 : 0);
    end
    for (int i = 4; i >= 1; i--) begin
      drive(3'd6, 1'b0, 16'h0000, 8'h00);
      chk("ovf_ret_pc", instruction_address, 16'(i * 16 + 17));
      chk("ovf_ret_cnt", ras_count, i - 1);
    end
    drive(3'd6, 1'b0, 16'h0000, 8'h00);
    chk("ovf_ret5_pc", instruction_address, 16'h0022);
    chk("ovf_ret5_unf", ras_underflow, 1'b1);
    chk("ovf_sticky", ras_overflow, 1'b1);
    do_reset();

    // Stall holds a call; release applies it
    go_to(16'h0030);
    stall = 1'b1;
    drive(3'd5, 1'b0, 16'h0200, 8'h00);
    chk("stall_pc", instruction_address, 16'h0030);
    chk("stall_cnt", ras_count, 3'd0);
    chk("stall_taken", taken, 1'b0);
    stall = 1'b0;
    step();
    chk("unstall_pc", instruction_address, 16'h0200);
    chk("unstall_cnt", ras_count, 3'd1);
    chk("unstall_taken", taken, 1'b1);
    // Back-to-back RET, CALL_REL, RET
    drive(3'd6, 1'b0, 16'h0000, 8'h00);
    chk("b2b_ret_pc", instruction_address, 16'h0031);
    drive(3'd4, 1'b0, 16'h0000, 8'h10);
    chk("callrel_pc", instruction_address, 16'h0042);
    chk("callrel_cnt", ras_count, 3'd1);
    drive(3'd6, 1'b0, 16'h0000, 8'h00);
    chk("b2b_ret2_pc", instruction_address, 16'h0032);
    chk("b2b_ret2_cnt", ras_count, 3'd0);
    chk("final_ovf", ras_overflow, 1'b0);
    chk("final_unf", ras_underflow, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
